// File: rtl/spike_rate_rx.sv
// Spike-line receiver: synchronizes spike_in, then reports spikes per window, inter-spike interval and a stall flag.
// state | meaning:  IDLE | measurement off, outputs held  ;  COUNT | back-to-back windows running
module spike_rate_rx #(
  parameter int CNT_W         = 16,
  parameter int WIN_W         = 16,
  parameter int STALL_WINDOWS = 4
) (
  input  logic             sysClk,
  input  logic             reset,
  input  logic             spike_in,
  input  logic             enable,
  input  logic [WIN_W-1:0] win_len,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  output logic             overflow,
  output logic [WIN_W-1:0] isi_out,
  output logic             isi_valid,
  output logic             stalled
);

  typedef enum logic {IDLE, COUNT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [WIN_W-1:0] WIN_MAX  = '1;
  localparam logic [7:0]       STALL_TH = 8'(STALL_WINDOWS);

  state_t           state, state_next;
  logic             s1, s2, s3, det;
  logic [WIN_W-1:0] win_ctr, isi_ctr, win_load;
  logic [CNT_W-1:0] spk_ctr, spk_sum;
  logic             sat_hit, sat_flag, isi_armed, active, win_close;
  logic [7:0]       empty_ctr, empty_next;

  assign det        = s2 & ~s3;
  assign win_load   = (win_len == '0) ? WIN_W'(1) : win_len;
  assign sat_hit    = det && (spk_ctr == CNT_MAX);
  assign spk_sum    = sat_hit ? CNT_MAX : spk_ctr + CNT_W'(det);
  assign active     = (state == COUNT) && enable;
  assign win_close  = active && (win_ctr == WIN_W'(1));
  assign empty_next = (empty_ctr == 8'hFF) ? empty_ctr : empty_ctr + 8'd1;

  always_ff @(posedge sysClk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable)  state_next = COUNT;
      COUNT:   if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sysClk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= spike_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge sysClk) begin
    if (reset) begin
      win_ctr    <= '0;
      spk_ctr    <= '0;
      sat_flag   <= 1'b0;
      isi_ctr    <= '0;
      isi_armed  <= 1'b0;
      empty_ctr  <= '0;
      rate_out   <= '0;
      rate_valid <= 1'b0;
      overflow   <= 1'b0;
      isi_out    <= '0;
      isi_valid  <= 1'b0;
      stalled    <= 1'b0;
    end else begin
      rate_valid <= 1'b0;
      isi_valid  <= 1'b0;
      if (state == IDLE) begin
        if (enable) begin
          win_ctr   <= win_load;
          spk_ctr   <= '0;
          sat_flag  <= 1'b0;
          isi_ctr   <= '0;
          isi_armed <= 1'b0;
        end
      end else if (active) begin
        // A det on the closing cycle is folded into the closing window via spk_sum.
        if (win_close) begin
          rate_out   <= spk_sum;
          overflow   <= sat_flag | sat_hit;
          rate_valid <= 1'b1;
          win_ctr    <= win_load;
          spk_ctr    <= '0;
          sat_flag   <= 1'b0;
        end else begin
          win_ctr  <= win_ctr - WIN_W'(1);
          spk_ctr  <= spk_sum;
          sat_flag <= sat_flag | sat_hit;
        end

        isi_ctr <= (isi_ctr == WIN_MAX) ? isi_ctr : isi_ctr + WIN_W'(1);
        if (det) begin
          if (isi_armed) begin
            isi_out   <= isi_ctr;
            isi_valid <= 1'b1;
          end
          isi_ctr   <= WIN_W'(1);
          isi_armed <= 1'b1;
          empty_ctr <= '0;
          stalled   <= 1'b0;
        end else if (win_close) begin
          if (spk_ctr == '0) begin
            empty_ctr <= empty_next;
            if (empty_next >= STALL_TH) stalled <= 1'b1;
          end else begin
            empty_ctr <= '0;
          end
        end
      end
    end
  end

endmodule

// File: doc/spike_rate_rx.md
# spike_rate_rx

Synchronous receiver for asynchronous spike trains produced by the free-running spike generators. It brings a spike line into the `sysClk` domain, detects each spike, and reports three things: spikes per programmable window, the inter-spike interval (ISI) in clock cycles, and a stall flag when the source has gone silent. It is the measurement and monitoring end of the spike interface.

## Interface
Parameters:
- `CNT_W`, 16: width of the spike count per window.
- `WIN_W`, 16: width of the window length and the ISI counter.
- `STALL_WINDOWS`, 4: number of consecutive empty windows that sets `stalled` (1..255).

Ports:
- `sysClk`  in  1  system clock; the only clock in the block.
- `reset`  in  1  synchronous, active-high reset.
- `spike_in`  in  1  asynchronous spike line. Each high phase and each low phase must last at least 2 `sysClk` periods; the source stretches its pulses to meet this.
- `enable`  in  1  level signal. High runs measurement windows; low returns the block to IDLE.
- `win_len`  in  WIN_W  window length in cycles. Sampled at every window start; a value of 0 is treated as 1.
- `rate_out`  out  CNT_W  spike count of the last completed window.
- `rate_valid`  out  1  one-cycle strobe: `rate_out` and `overflow` have just been updated.
- `overflow`  out  1  set when the last completed window's count saturated.
- `isi_out`  out  WIN_W  cycles between the last two detected spikes.
- `isi_valid`  out  1  one-cycle strobe: `isi_out` has just been updated.
- `stalled`  out  1  the source is considered dead (see Operation).

## Operation
- **Synchronizer:** three flops, `s1<=spike_in`, `s2<=s1`, `s3<=s2`. Edge detect is `det = s2 & ~s3`, asserted for exactly one cycle per rising edge of `spike_in`.
- **States:** IDLE and COUNT.
  - IDLE → COUNT on `enable=1`. On entry, load `win_ctr<=max(win_len,1)`, `spk_ctr<=0`, `isi_armed<=0`.
  - COUNT → IDLE on `enable=0`. The partial window is discarded, no `rate_valid` is issued, and the outputs hold their values.
- **Window:** in COUNT, `win_ctr` decrements every cycle.
  - On a cycle with `win_ctr==1`:
    - `rate_out<=sat(spk_ctr+det)` and `overflow<=` (saturation occurred in this window).
    - `rate_valid<=1` and `win_ctr<=max(win_len,1)`.
    - `spk_ctr<=0` and the saturation flag is cleared.
  - Otherwise `spk_ctr<=sat(spk_ctr+det)`.
  - Windows are back to back with no gap cycle. A `det` on the final cycle of a window counts toward that window.
- **Saturation:** `spk_ctr` saturates at 2^CNT_W−1. The overflow flag is sticky within a window.
- **ISI counter:**
  - `isi_ctr` increments every cycle in COUNT and saturates at 2^WIN_W−1.
  - On `det`: if `isi_armed`, then `isi_out<=isi_ctr` and `isi_valid<=1`. In either case `isi_ctr<=1` and `isi_armed<=1`.
  - Result: spikes detected at cycles a and b give `isi_out=b−a`. The first spike after entering COUNT only arms the measurement.
- **Stall detection:**
  - `empty_ctr` (8-bit, saturating) increments at each window close with a final count of 0. A close with a nonzero count clears it.
  - `stalled<=1` when `empty_ctr` reaches `STALL_WINDOWS`.
  - Any `det` clears both `empty_ctr` and `stalled` on the next edge.
  - `stalled` holds its value in IDLE.
- **Simultaneous events:**
  - `reset` beats everything.
  - `enable=0` beats a window close in the same cycle (no strobe).
  - `det` together with a window close is counted in the closing window and also clears stall.
  - A change to `win_len` mid-window takes effect at the next reload.

## Timing
- **Reset:** every register and output is 0, state is IDLE, synchronizer flops are 0. Reset is honoured in any state and discards any partial window.
- **Spike to `det` latency:** a `spike_in` rise first sampled by `s1` at edge k produces `det` high during the cycle after edge k+1. The counters update at edge k+2.
- **Strobes:** `rate_valid` and `isi_valid` are registered and high for exactly one cycle. Both may be high in the same cycle.
- **Window timing:** `enable` rising at edge e makes the first `rate_valid` visible after edge e+win_len. A new strobe follows every `win_len` cycles after that.
- **Throughput:** sustained detection up to one spike per 4 cycles (the minimum legal high+low period).

## Test plan
- **Reset:** reset for 3 cycles with `spike_in` toggling → all outputs 0, no strobes, state IDLE.
- **Periodic count and ISI:** `win_len=100`, spikes every 10 cycles (high 3, low 7) → `rate_out=10`, `rate_valid` every 100 cycles, `isi_out=10` with `isi_valid` on every spike after the first.
- **Saturation:** `CNT_W=4`, `win_len=200`, spikes every 4 cycles → `rate_out=15`, `overflow=1`. The next window, with 5 spikes, gives `rate_out=5`, `overflow=0`.
- **Stall:** `STALL_WINDOWS=4`, `win_len=50`, no spikes → `stalled=1` at the 4th window close. One spike → `stalled=0` within 4 cycles of the rise.
- **Boundary events:**
  - Spike whose `det` lands on the final window cycle → counted in the closing window.
  - `win_len=0` → behaves as 1, giving `rate_valid` every cycle.
- **Abort:** `enable` low at cycle 40 of a 100-cycle window → no `rate_valid`, outputs hold. Re-enabling starts a fresh full window and the first spike does not produce `isi_valid`.
